// File: rtl/joint_unistepper_pkg.sv
// Shared definitions for the unipolar stepper joint driver: drive modes,
// per-mode index steps and the phase-index to coil-pattern decode.
package joint_unistepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'd0;
    localparam logic [1:0] MODE_FULL = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;

    // Phase index is kept in half-step units; whole-step modes move two.
    localparam logic [2:0] STEP_HALF  = 3'd1;
    localparam logic [2:0] STEP_WHOLE = 3'd2;

    // Mode code 3 behaves exactly like half-step.
    function automatic logic [1:0] mode_norm(input logic [1:0] mode);
        return (mode == 2'd3) ? MODE_HALF : mode;
    endfunction

    function automatic logic [2:0] mode_step(input logic [1:0] mode);
        return (mode == MODE_HALF) ? STEP_HALF : STEP_WHOLE;
    endfunction

    // Even index 2k energises coil k; odd 2k+1 energises coils k and k+1 (mod 4).
    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        logic [1:0] k;
        pat = '0;
        k = idx[2:1];
        pat[k] = 1'b1;
        if (idx[0]) begin
            pat[k + 2'd1] = 1'b1;
        end
        return pat;
    endfunction

endpackage

// File: rtl/joint_unistepper_drive_if.sv
// Command/status bundle between the joint command registers and one axis driver.
interface joint_unistepper_drive_if #(
    parameter int FREQ_WIDTH = 32,
    parameter int FB_WIDTH   = 32
);
    logic                         jointEnable;
    logic signed [FREQ_WIDTH-1:0] jointFreqCmd;
    logic [1:0]                   jointMode;
    logic signed [FB_WIDTH-1:0]   jointFeedback;
    logic                         a1;
    logic                         a2;
    logic                         b1;
    logic                         b2;
    logic                         jointIdle;

    modport master (
        output jointEnable, jointFreqCmd, jointMode,
        input  jointFeedback, a1, a2, b1, b2, jointIdle
    );

    modport slave (
        input  jointEnable, jointFreqCmd, jointMode,
        output jointFeedback, a1, a2, b1, b2, jointIdle
    );
endinterface

// File: rtl/joint_step_timer.sv
// Step-rate timer: turns a signed half-period command into a single-cycle
// advance pulse every 2*(|cmd|+1) clocks plus the registered direction.
module joint_step_timer
    import joint_unistepper_pkg::*;
#(
    parameter int FREQ_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [FREQ_WIDTH-1:0] freq_cmd,
    output logic                         advance,
    output logic                         dir
);

    localparam logic [FREQ_WIDTH-1:0] MOST_NEG = {1'b1, {(FREQ_WIDTH-1){1'b0}}};
    localparam logic [FREQ_WIDTH-1:0] MOST_POS = {1'b0, {(FREQ_WIDTH-1){1'b1}}};

    logic [FREQ_WIDTH-1:0] abs_d;
    logic [FREQ_WIDTH-1:0] abs_q;
    logic [FREQ_WIDTH-1:0] cnt_q;
    logic                  dir_q;
    logic                  tog_q;
    logic                  run;
    logic                  expire;

    // Magnitude of the command; the most negative value saturates to max positive.
    always_comb begin
        abs_d = $unsigned(freq_cmd);
        if (freq_cmd[FREQ_WIDTH-1]) begin
            if ($unsigned(freq_cmd) == MOST_NEG) begin
                abs_d = MOST_POS;
            end else begin
                abs_d = $unsigned(-freq_cmd);
            end
        end
    end

    // Command magnitude and sign are sampled together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_q <= '0;
            dir_q <= 1'b0;
        end else begin
            abs_q <= abs_d;
            dir_q <= freq_cmd[FREQ_WIDTH-1];
        end
    end

    assign run     = enable && (abs_q != '0);
    assign expire  = run && (cnt_q >= abs_q);
    assign advance = expire && tog_q;
    assign dir     = dir_q;

    // Half-period counter and toggle; both held at zero while halted or disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else if (expire) begin
            cnt_q <= '0;
            tog_q <= ~tog_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/joint_unistepper_drive.sv
// Unipolar 4-coil stepper joint driver: phase index, position feedback,
// drive-mode remapping, idle hold reduction and registered coil outputs.
module joint_unistepper_drive
    import joint_unistepper_pkg::*;
#(
    parameter int FREQ_WIDTH  = 32,
    parameter int FB_WIDTH    = 32,
    parameter int IDLE_CYCLES = 1000,
    parameter int PWM_BITS    = 4,
    parameter int HOLD_DUTY   = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    joint_unistepper_drive_if.slave jif
);

    localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    logic                en;
    logic                adv;
    logic                dir;
    logic                mode_chg;
    logic                step_en;
    logic                hold_gate;
    logic [1:0]          mode_q;
    logic [1:0]          mode_applied_q;
    logic [2:0]          idx_q;
    logic [2:0]          idx_d;
    logic [FB_WIDTH-1:0] fb_q;
    logic [FB_WIDTH-1:0] fb_d;
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic [IDLE_W-1:0]   idle_cnt_d;
    logic                idle_q;
    logic                idle_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [3:0]          coil_q;
    logic [3:0]          coil_d;

    assign en = jif.jointEnable;

    joint_step_timer #(
        .FREQ_WIDTH(FREQ_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (en),
        .freq_cmd (jif.jointFreqCmd),
        .advance  (adv),
        .dir      (dir)
    );

    // A pending mode change is only applied while enabled, so the index
    // never re-enters a wave/full mode misaligned after a disabled period.
    assign mode_chg = en && (mode_q != mode_applied_q);
    assign step_en  = adv && !mode_chg;

    // Next index, feedback and idle state; a mode remap swallows a coincident advance.
    always_comb begin
        idx_d = idx_q;
        fb_d  = fb_q;
        if (mode_chg) begin
            case (mode_q)
                MODE_WAVE: idx_d = idx_q & 3'b110;
                MODE_FULL: idx_d = idx_q | 3'b001;
                default:   idx_d = idx_q;
            endcase
        end else if (adv) begin
            idx_d = dir ? (idx_q - mode_step(mode_q)) : (idx_q + mode_step(mode_q));
            fb_d  = dir ? (fb_q - 1'b1) : (fb_q + 1'b1);
        end

        idle_cnt_d = idle_cnt_q;
        if (!en || step_en || mode_chg) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        idle_d = en && (idle_cnt_d == IDLE_MAX);
    end

    // Coil drive for the current index, chopped by the hold PWM while idle.
    always_comb begin
        hold_gate = !idle_q || (int'(pwm_q) < HOLD_DUTY);
        coil_d    = '0;
        if (en && hold_gate) begin
            coil_d = coil_pattern(idx_q);
        end
    end

    // Mode sampling and the record of the mode the index is aligned to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= MODE_WAVE;
            mode_applied_q <= MODE_WAVE;
        end else begin
            mode_q <= mode_norm(jif.jointMode);
            if (en) begin
                mode_applied_q <= mode_q;
            end
        end
    end

    // Position state, idle tracking, free-running PWM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            fb_q       <= '0;
            idle_cnt_q <= '0;
            idle_q     <= 1'b0;
            pwm_q      <= '0;
            coil_q     <= '0;
        end else begin
            idx_q      <= idx_d;
            fb_q       <= fb_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
            pwm_q      <= pwm_q + 1'b1;
            coil_q     <= coil_d;
        end
    end

    assign jif.a1            = coil_q[0];
    assign jif.a2            = coil_q[1];
    assign jif.b1            = coil_q[2];
    assign jif.b2            = coil_q[3];
    assign jif.jointIdle     = idle_q;
    assign jif.jointFeedback = fb_q;

endmodule

// File: tb/tb_joint_unistepper_drive.sv
// Self-checking bench for joint_unistepper_drive: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_joint_unistepper_drive;

    localparam int IDLE_CYC = 16;
    localparam int HOLD     = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    joint_unistepper_drive_if #(.FREQ_WIDTH(8), .FB_WIDTH(8)) jif ();

    joint_unistepper_drive #(
        .FREQ_WIDTH  (8),
        .FB_WIDTH    (8),
        .IDLE_CYCLES (IDLE_CYC),
        .PWM_BITS    (4),
        .HOLD_DUTY   (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .jif   (jif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit       en;
        int       cmd;
        int       mode;
        int       ncyc;
        bit       chk_coils;
        int       coils;
        int       fb;
        int       idle;
    } vec_t;

    vec_t vecs[15];

    // reference model state
    int r_mag, r_run, r_mode, r_mode_applied, r_idx, r_fb, r_quiet, r_pwm, r_coils, r_idle;
    bit r_neg;

    function automatic int coils_now();
        return int'({jif.b2, jif.b1, jif.a2, jif.a1});
    endfunction

    function automatic int fb_now();
        return int'($signed(jif.jointFeedback));
    endfunction

    function automatic int ref_pattern(input int idx);
        int k;
        int p;
        k = idx / 2;
        p = 1 << k;
        if (idx % 2 == 1) p = p | (1 << ((k + 1) % 4));
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input int cmd, input int mode);
        jif.jointEnable  = en;
        jif.jointFreqCmd = 8'(cmd);
        jif.jointMode    = 2'(mode);
    endtask

    task automatic ref_reset();
        r_mag = 0; r_run = 0; r_mode = 0; r_mode_applied = 0; r_idx = 0; r_fb = 0;
        r_quiet = 0; r_pwm = 0; r_coils = 0; r_idle = 0; r_neg = 0;
    endtask

    // One clock edge of the reference: advances come every 2*(|cmd|+1) running edges.
    task automatic ref_step(input bit en, input int cmd, input int mode);
        bit run;
        bit adv;
        bit chg;
        bit gate;
        int step;
        gate = (r_idle == 0) || (r_pwm < HOLD);
        r_coils = (en && gate) ? ref_pattern(r_idx) : 0;
        run = en && (r_mag != 0);
        adv = 0;
        if (run) begin
            r_run++;
            adv = ((r_run % (2 * (r_mag + 1))) == 0);
        end else begin
            r_run = 0;
        end
        chg = en && (r_mode != r_mode_applied);
        if (chg) begin
            adv = 0;
            if (r_mode == 0) r_idx = r_idx & 6;
            else if (r_mode == 1) r_idx = r_idx | 1;
        end else if (adv) begin
            step = (r_mode == 2) ? 1 : 2;
            r_idx = (r_idx + (r_neg ? 8 - step : step)) % 8;
            r_fb = r_fb + (r_neg ? -1 : 1);
            if (r_fb > 127) r_fb -= 256;
            if (r_fb < -128) r_fb += 256;
        end
        if (!en || adv || chg) r_quiet = 0;
        else if (r_quiet < IDLE_CYC) r_quiet++;
        r_idle = (en && r_quiet == IDLE_CYC) ? 1 : 0;
        r_pwm = (r_pwm + 1) % 16;
        if (en) r_mode_applied = r_mode;
        r_mode = (mode == 3) ? 2 : mode;
        r_mag = (cmd == -128) ? 127 : ((cmd < 0) ? -cmd : cmd);
        r_neg = (cmd < 0);
    endtask

    task automatic rand_cycle(input bit en, input int cmd, input int mode, input int cyc);
        int act;
        int exp;
        drive(en, cmd, mode);
        ref_step(en, cmd, mode);
        tick();
        act = (coils_now() << 16) | (int'(jif.jointIdle) << 12) | (fb_now() & 255);
        exp = (r_coils << 16) | (r_idle << 12) | (r_fb & 255);
        if (act !== exp) $display("FAIL rand_cycle_%0d: coils/idle/fb got 0x%0h expected 0x%0h", cyc, act, exp);
        n_tests++;
        if (act !== exp) n_fail++;
    endtask

    initial begin
        int n;
        int cnt_a1, cnt_a2, cnt_b, idle_all;
        int cyc;
        n_tests = 0;
        n_fail  = 0;

        // {en, cmd, mode, cycles, check coils, coils {b2,b1,a2,a1}, feedback, idle}
        vecs[0]  = '{1'b1,  3, 2, 10, 1'b1, 4'b0011, 1, 0};
        vecs[1]  = '{1'b1,  3, 2,  8, 1'b1, 4'b0010, 2, 0};
        vecs[2]  = '{1'b1,  3, 2,  8, 1'b1, 4'b0110, 3, 0};
        vecs[3]  = '{1'b1,  3, 2,  8, 1'b1, 4'b0100, 4, 0};
        vecs[4]  = '{1'b1,  3, 2,  8, 1'b1, 4'b1100, 5, 0};
        vecs[5]  = '{1'b1,  3, 2,  8, 1'b1, 4'b1000, 6, 0};
        vecs[6]  = '{1'b1,  3, 2,  8, 1'b1, 4'b1001, 7, 0};
        vecs[7]  = '{1'b1,  3, 2,  8, 1'b1, 4'b0001, 8, 0};
        vecs[8]  = '{1'b1,  0, 2,  3, 1'b1, 4'b0001, 8, 0};
        vecs[9]  = '{1'b1, -3, 0, 10, 1'b1, 4'b1000, 7, 0};
        vecs[10] = '{1'b1, -3, 0,  8, 1'b1, 4'b0100, 6, 0};
        vecs[11] = '{1'b1, -3, 0,  8, 1'b1, 4'b0010, 5, 0};
        vecs[12] = '{1'b1, -3, 1,  3, 1'b1, 4'b0110, 5, 0};
        vecs[13] = '{1'b1, -3, 1,  5, 1'b1, 4'b0011, 4, 0};
        vecs[14] = '{1'b1,  0, 1, 20, 1'b0, 0,       4, 1};

        rst_n = 1'b0;
        drive(1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_coils", coils_now(), 0);
        check("reset_fb", fb_now(), 0);
        check("reset_idle", int'(jif.jointIdle), 0);
        rst_n = 1'b1;

        // directed table: half-step forward, wave reverse, mode remap, hold entry
        for (int v = 0; v < 15; v++) begin
            drive(vecs[v].en, vecs[v].cmd, vecs[v].mode);
            repeat (vecs[v].ncyc) tick();
            if (vecs[v].chk_coils) check($sformatf("vec%0d_coils", v), coils_now(), vecs[v].coils);
            check($sformatf("vec%0d_fb", v), fb_now(), vecs[v].fb);
            check($sformatf("vec%0d_idle", v), int'(jif.jointIdle), vecs[v].idle);
        end

        // hold PWM duty over one full period (index 1: a1+a2 energised)
        cnt_a1 = 0; cnt_a2 = 0; cnt_b = 0; idle_all = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt_a1 += int'(jif.a1);
            cnt_a2 += int'(jif.a2);
            cnt_b  += int'(jif.b1) + int'(jif.b2);
            if (!jif.jointIdle) idle_all = 0;
        end
        check("hold_a1_duty", cnt_a1, 4);
        check("hold_a2_duty", cnt_a2, 4);
        check("hold_b_off", cnt_b, 0);
        check("hold_idle_stays", idle_all, 1);

        // first advance out of hold restores full drive
        drive(1'b1, 1, 1);
        n = 0;
        while (n < 20 && fb_now() == 4) begin
            tick();
            n++;
        end
        check("restore_adv_latency", n, 5);
        check("restore_idle_clear", int'(jif.jointIdle), 0);
        tick();
        check("restore_full_drive", coils_now(), 4'b0110);
        check("restore_fb", fb_now(), 5);

        // enable drop mid-period, then re-enable waits a full period
        jif.jointEnable = 1'b0;
        tick();
        check("dis_coils_off", coils_now(), 0);
        check("dis_idle_low", int'(jif.jointIdle), 0);
        repeat (3) tick();
        check("dis_fb_held", fb_now(), 5);
        jif.jointEnable = 1'b1;
        repeat (3) tick();
        check("reen_no_early_adv", fb_now(), 5);
        check("reen_coils_held_idx", coils_now(), 4'b0110);
        tick();
        check("reen_full_period_adv", fb_now(), 6);

        // feedback wrap 127 -> -128
        n = 0;
        while (n < 1000 && fb_now() != 127) begin
            tick();
            n++;
        end
        check("wrap_reach_127", fb_now(), 127);
        n = 0;
        while (n < 8 && fb_now() == 127) begin
            tick();
            n++;
        end
        check("wrap_to_neg128", fb_now(), -128);

        // asynchronous reset while stepping
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_coils_idle", (coils_now() << 1) | int'(jif.jointIdle), 0);
        check("rst_async_fb", fb_now(), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_release_a1_only", coils_now(), 4'b0001);
        check("rst_release_fb", fb_now(), 0);

        // randomized run against the reference model
        rst_n = 1'b0;
        drive(1'b0, 0, 0);
        tick();
        ref_reset();
        rst_n = 1'b1;
        cyc = 0;
        for (int s = 0; s < 40; s++) begin
            int len;
            int r_en;
            int r_md;
            int r_cmd;
            int sel;
            len  = int'($urandom_range(8, 60));
            r_en = ($urandom_range(0, 4) != 0) ? 1 : 0;
            r_md = int'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 9));
            if (sel == 0) r_cmd = 0;
            else if (sel == 1) begin
                r_cmd = -128;
                len = 560;
            end else begin
                r_cmd = int'($urandom_range(1, 5));
                if ($urandom_range(0, 1) == 1) r_cmd = -r_cmd;
            end
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 19) == 0) r_md = int'($urandom_range(0, 3));
                if ($urandom_range(0, 24) == 0) r_en = 1 - r_en;
                rand_cycle(r_en[0], r_cmd, r_md, cyc);
                cyc++;
            end
            // commands only change through a zero so every run restarts cleanly
            for (int c = 0; c < 2; c++) begin
                rand_cycle(r_en[0], 0, r_md, cyc);
                cyc++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
